mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Round-robin arbiter that shares one port of the dual-port SRAM wrapper between N_REQ requesters, e.g. the scalar core's data interface and the vector unit's load/store unit. It uses the same req/gnt/rvalid/err handshake on both sides. A small in-order ID FIFO records which requester owns each outstanding access, so each response returns only to the requester that issued it. The block sits between the requesters and one `data_*_a`/`data_*_b` port group of the memory wrapper.

## Interface
- N_REQ, 2, number of requesters (2..8)
- DATA_WIDTH, 32, data bus width
- ADDR_WIDTH, 32, byte address width
- MAX_OUT, 2, maximum outstanding accesses (ID FIFO depth, power of two, ≥1)
- clk  input  1  clock; all state on posedge
- rst  input  1  reset, asynchronous, active-low
- req_i  input  N_REQ  per-requester request
- addr_i  input  N_REQ*ADDR_WIDTH  per-requester byte address; slice i belongs to requester i
- we_i  input  N_REQ  per-requester write enable
- be_i  input  N_REQ*DATA_WIDTH/8  per-requester byte enables
- wdata_i  input  N_REQ*DATA_WIDTH  per-requester write data
- gnt_o  output  N_REQ  per-requester grant; one-hot or zero
- rvalid_o  output  N_REQ  per-requester response valid; one-hot or zero
- err_o  output  N_REQ  per-requester error; qualified by rvalid_o
- rdata_o  output  DATA_WIDTH  read data, broadcast to all requesters; qualified by rvalid_o
- mem_req_o  output  1  memory request
- mem_addr_o / mem_we_o / mem_be_o / mem_wdata_o  output  ADDR_WIDTH / 1 / DATA_WIDTH/8 / DATA_WIDTH  muxed from the winning requester
- mem_gnt_i, mem_rvalid_i, mem_err_i  input  1 each  memory handshake
- mem_rdata_i  input  DATA_WIDTH  memory read data
- out_cnt_o  output  $clog2(MAX_OUT)+1  number of outstanding accesses
- proto_err_o  output  1  sticky flag: mem_rvalid_i arrived while no access was outstanding

## Operation
- Winner selection:
  - Combinational round-robin over req_i, starting at pointer `rr_ptr`.
  - The winner is the first i ≥ rr_ptr (wrapping modulo N_REQ) with req_i[i]=1.
- Issue gating:
  - full = (out_cnt == MAX_OUT).
  - mem_req_o = |req_i & !full.
  - mem_addr/we/be/wdata are driven from the winner's slices. When no request is issued they are undefined (don't-care).
- Grant:
  - gnt_o[winner] = mem_req_o & mem_gnt_i.
  - All other gnt_o bits are 0.
- Handshake (mem_req_o & mem_gnt_i):
  - Push the winner index into the ID FIFO.
  - Set rr_ptr = (winner+1) mod N_REQ.
  - With no handshake, rr_ptr holds.
- Response (mem_rvalid_i with FIFO non-empty):
  - Pop the FIFO head h.
  - rvalid_o[h] = 1 and err_o[h] = mem_err_i.
  - rdata_o = mem_rdata_i, combinational pass-through.
- Response with FIFO empty:
  - The response is dropped: all rvalid_o bits stay 0.
  - proto_err_o is set and stays set until reset.
- Push and pop in the same cycle: out_cnt is unchanged, and pointers advance independently.
- When full, no request is issued in that cycle, even if a pop occurs in the same cycle. Issue resumes the following cycle.
- Requester rules:
  - A requester holds req/addr/we/be/wdata stable until its gnt_o.
  - A requester may drop req_i before being granted. The drop is harmless; the arbiter keeps no state about pending requests.
- Responses are returned strictly in issue order.

## Timing
- Grant is combinational, with zero added latency. With the SRAM wrapper, rvalid_o follows gnt_o by exactly 1 cycle.
- Back-to-back issue with MAX_OUT=2 gives 1 access per cycle sustained.
- Reset values:
  - rr_ptr=0, FIFO empty, out_cnt_o=0, proto_err_o=0.
  - With the FIFO empty: rvalid_o=0 and err_o=0; gnt_o follows req_i & mem_gnt_i gating; rdata_o=mem_rdata_i.
- Asserting rst while accesses are outstanding discards all FIFO entries. Responses arriving after reset release set proto_err_o. The system must quiesce the memory before resetting the arbiter.

## Configuration
- MEM_PORT_ARBITER_FIXED_PRIO_EN defined:
  - Fixed priority: the lowest requester index always wins.
  - rr_ptr is removed and treated as 0.
  - A continuously requesting low index can starve higher indices; this is intended for a latency-critical scalar core on index 0.
- Macro undefined: round-robin as described above (default).

## Test plan
- Single access: N_REQ=2, req_i=01, addr=0x100 read, mem_gnt=1 -> gnt_o=01 same cycle; mem_req_o=1 with mem_addr_o=0x100; next cycle rvalid_o=01 with rdata_o=mem_rdata_i, out_cnt_o returns to 0.
- Round-robin fairness: req_i=11 held for 4 cycles with mem_gnt=1 -> gnt_o sequence 01,10,01,10; rvalid_o follows one cycle later in the same order. With FIXED_PRIO_EN the sequence is 01,01,01,01.
- Back-pressure: MAX_OUT=2, req_i=11, memory holds rvalid low for 3 cycles -> two grants, then mem_req_o=0 and gnt_o=00 while out_cnt_o=2. Issue resumes in the cycle after the first rvalid.
- Error routing: requester 1 write with mem_err_i=1 on the response -> err_o=10 with rvalid_o=10; err_o[0] stays 0.
- Spurious response: mem_rvalid_i=1 with nothing outstanding -> rvalid_o=00, proto_err_o=1 and it stays 1 until rst goes low.
- Reset mid-operation: grant one access, assert rst before its rvalid -> out_cnt_o=0 and proto_err_o=0 during reset; the late rvalid after release sets proto_err_o=1.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one SRAM port between N_REQ requesters using the
// req/gnt/rvalid/err handshake. A small in-order ID FIFO remembers which
// requester owns each outstanding access, so every response goes back only to
// the requester that issued it.
// Optional macro MEM_PORT_ARBITER_FIXED_PRIO_EN: the lowest requester index
// always wins and the round-robin pointer is removed (default: round-robin).
module mem_port_arbiter #(
  parameter int N_REQ      = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_OUT    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_i,
  input  logic [N_REQ*ADDR_WIDTH-1:0]   addr_i,
  input  logic [N_REQ-1:0]              we_i,
  input  logic [N_REQ*DATA_WIDTH/8-1:0] be_i,
  input  logic [N_REQ*DATA_WIDTH-1:0]   wdata_i,
  output logic [N_REQ-1:0]              gnt_o,
  output logic [N_REQ-1:0]              rvalid_o,
  output logic [N_REQ-1:0]              err_o,
  output logic [DATA_WIDTH-1:0]         rdata_o,
  output logic                          mem_req_o,
  output logic [ADDR_WIDTH-1:0]         mem_addr_o,
  output logic                          mem_we_o,
  output logic [DATA_WIDTH/8-1:0]       mem_be_o,
  output logic [DATA_WIDTH-1:0]         mem_wdata_o,
  input  logic                          mem_gnt_i,
  input  logic                          mem_rvalid_i,
  input  logic                          mem_err_i,
  input  logic [DATA_WIDTH-1:0]         mem_rdata_i,
  output logic [$clog2(MAX_OUT):0]      out_cnt_o,
  output logic                          proto_err_o
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CW = $clog2(MAX_OUT) + 1;
  localparam int BW = DATA_WIDTH / 8;
  localparam logic [IW-1:0] LAST_IDX  = IW'(N_REQ - 1);
  localparam logic [PW-1:0] LAST_SLOT = PW'(MAX_OUT - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(MAX_OUT);

  logic [IW-1:0] r_fifo [MAX_OUT];
  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [CW-1:0] r_outCnt;
  logic          r_protoErr;

  logic [IW-1:0] w_ptr;
  logic [IW-1:0] w_winner;
  logic [IW-1:0] w_head;
  logic          w_full;
  logic          w_push;
  logic          w_pop;

`ifdef MEM_PORT_ARBITER_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  logic [IW-1:0] r_rrPtr;

  // Move the search start just past each requester that completes a handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rrPtr <= '0;
    end else if (w_push) begin
      r_rrPtr <= (w_winner == LAST_IDX) ? '0 : w_winner + 1'b1;
    end
  end

  assign w_ptr = r_rrPtr;
`endif

  // Winner is the first requesting index at or after the pointer, wrapping around
  always_comb begin
    int idx;
    w_winner = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(w_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req_i[idx]) w_winner = IW'(idx);
    end
  end

  assign w_full      = (r_outCnt == FULL_CNT);
  assign mem_req_o   = (|req_i) & ~w_full;
  assign w_push      = mem_req_o & mem_gnt_i;
  assign w_pop       = mem_rvalid_i & (r_outCnt != '0);
  assign w_head      = r_fifo[r_rdPtr];

  assign mem_addr_o  = addr_i[int'(w_winner)*ADDR_WIDTH +: ADDR_WIDTH];
  assign mem_we_o    = we_i[w_winner];
  assign mem_be_o    = be_i[int'(w_winner)*BW +: BW];
  assign mem_wdata_o = wdata_i[int'(w_winner)*DATA_WIDTH +: DATA_WIDTH];
  assign rdata_o     = mem_rdata_i;
  assign out_cnt_o   = r_outCnt;
  assign proto_err_o = r_protoErr;

  // Grant goes to the winner on a handshake; the response goes to the FIFO head owner
  always_comb begin
    gnt_o    = '0;
    rvalid_o = '0;
    err_o    = '0;
    if (w_push) gnt_o[w_winner] = 1'b1;
    if (w_pop) begin
      rvalid_o[w_head] = 1'b1;
      err_o[w_head]    = mem_err_i;
    end
  end

  // Remember the owner of each accepted access in issue order
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wrPtr] <= w_winner;
  end

  // Track FIFO pointers, occupancy and the sticky stray-response flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_outCnt   <= '0;
      r_protoErr <= 1'b0;
    end else begin
      if (w_push) r_wrPtr <= (r_wrPtr == LAST_SLOT) ? '0 : r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= (r_rdPtr == LAST_SLOT) ? '0 : r_rdPtr + 1'b1;
      if (w_push && !w_pop) begin
        r_outCnt <= r_outCnt + 1'b1;
      end else if (w_pop && !w_push) begin
        r_outCnt <= r_outCnt - 1'b1;
      end
      if (mem_rvalid_i && (r_outCnt == '0)) r_protoErr <= 1'b1;
    end
  end

endmodule
